// File: rtl/palindrome_bit_serializer.sv
// palindrome_bit_serializer
//   Parallel-to-serial front end for the 3-bit palindrome detector. Words
//   arrive on a valid/ready handshake and are shifted out one bit per clock.
//   A one-word pending buffer keeps back-to-back words contiguous on x_o.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   data_i     parallel word (DATA_WIDTH bits)
//   valid_i    data_i valid
//   ready_o    a word can be accepted this cycle (= no word pending)
//   x_o        serial bit to the detector's x_i
//   x_valid_o  x_o carries a real data bit
//   last_o     x_o is the final bit of its word
//   busy_o     a word is being shifted or is pending
module palindrome_bit_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  x_o,
  output logic                  x_valid_o,
  output logic                  last_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] sreg_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] pend_q;
  logic                  pend_vld_q;

  logic                  accept;
  logic                  on_last;
  logic [DATA_WIDTH-1:0] sreg_shifted;

  // All outputs decode registered state only, so reset clears them
  // asynchronously and nothing depends combinationally on valid_i.
  assign ready_o   = !pend_vld_q;
  assign accept    = valid_i && ready_o;
  assign on_last   = (state_q == SHIFT) && (cnt_q == CW'(DATA_WIDTH-1));
  assign x_valid_o = (state_q == SHIFT);
  assign x_o       = x_valid_o && (MSB_FIRST ? sreg_q[DATA_WIDTH-1] : sreg_q[0]);
  assign last_o    = on_last;
  assign busy_o    = (state_q == SHIFT) || pend_vld_q;

  // Shift toward the output end with zero fill.
  assign sreg_shifted = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sreg_q  <= data_i;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (!on_last) begin
            sreg_q <= sreg_shifted;
            cnt_q  <= cnt_q + 1'b1;
            if (accept) begin
              pend_q     <= data_i;
              pend_vld_q <= 1'b1;
            end
          end else if (pend_vld_q) begin
            // ready_o is low here, so no new word can collide with the reload.
            sreg_q     <= pend_q;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
          end else if (accept) begin
            // Buffer empty on the last bit: bypass it and load directly.
            sreg_q <= data_i;
            cnt_q  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_palindrome_bit_serializer.sv
module tb_palindrome_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l;
  logic       ready_m, x_m, xv_m, last_m, busy_m;
  logic       ready_l, x_l, xv_l, last_l, busy_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  palindrome_bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .data_i(data_m), .valid_i(valid_m),
    .ready_o(ready_m), .x_o(x_m), .x_valid_o(xv_m), .last_o(last_m), .busy_o(busy_m));

  palindrome_bit_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_i(data_l), .valid_i(valid_l),
    .ready_o(ready_l), .x_o(x_l), .x_valid_o(xv_l), .last_o(last_l), .busy_o(busy_l));

  // One table row: a single isolated word on the chosen instance, with the
  // expected serial stream written first-bit-on-the-left.
  typedef struct {
    string      name;
    bit         lsb;
    logic [7:0] data;
    logic [7:0] stream;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk({name, " x_valid"}, xv_m, 1'b0);
    chk({name, " x"},       x_m,  1'b0);
    chk({name, " last"},    last_m, 1'b0);
    chk({name, " busy"},    busy_m, 1'b0);
    chk({name, " ready"},   ready_m, 1'b1);
  endtask

  // Present one word, then check all 8 bit cycles and the idle cycle after.
  // Entered and left at a negedge.
  task automatic run_word(input string name, input bit lsb, input logic [7:0] d,
                          input logic [7:0] exp);
    if (lsb) begin data_l = d; valid_l = 1'b1; end
    else     begin data_m = d; valid_m = 1'b1; end
    @(posedge clk); #1;
    valid_l = 1'b0; valid_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("%s b%0d x_valid", name, i), lsb ? xv_l : xv_m, 1'b1);
      chk($sformatf("%s b%0d x", name, i),       lsb ? x_l : x_m, exp[7-i]);
      chk($sformatf("%s b%0d last", name, i),    lsb ? last_l : last_m, i == 7);
      chk($sformatf("%s b%0d busy", name, i),    lsb ? busy_l : busy_m, 1'b1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({name, " after x_valid"}, lsb ? xv_l : xv_m, 1'b0);
    chk({name, " after busy"},    lsb ? busy_l : busy_m, 1'b0);
  endtask

  initial begin
    logic [15:0] s2;

    vecs[0] = '{"msb_A5", 1'b0, 8'hA5, 8'b1010_0101};
    vecs[1] = '{"msb_3C", 1'b0, 8'h3C, 8'b0011_1100};
    vecs[2] = '{"msb_80", 1'b0, 8'h80, 8'b1000_0000};
    vecs[3] = '{"lsb_01", 1'b1, 8'h01, 8'b1000_0000};
    vecs[4] = '{"lsb_B4", 1'b1, 8'hB4, 8'b0010_1101};

    reset = 1'b0; data_m = '0; data_l = '0; valid_m = 1'b0; valid_l = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("in_reset");
    chk("in_reset ready_l", ready_l, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_idle($sformatf("idle c%0d", c));
    end

    // Table: isolated words on both bit orders
    foreach (vecs[k]) run_word(vecs[k].name, vecs[k].lsb, vecs[k].data, vecs[k].stream);

    // Back-to-back: F0 then 0F into the pending buffer
    s2 = 16'b1111_0000_0000_1111;
    data_m = 8'hF0; valid_m = 1'b1;
    @(posedge clk); #1;
    data_m = 8'h0F;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk($sformatf("b2b c%0d x_valid", c), xv_m, 1'b1);
      chk($sformatf("b2b c%0d x", c),       x_m, s2[16-c]);
      chk($sformatf("b2b c%0d last", c),    last_m, (c == 8) || (c == 16));
      chk($sformatf("b2b c%0d ready", c),   ready_m, !(c >= 2 && c <= 8));
      @(posedge clk); #1;
      if (c == 1) valid_m = 1'b0;
    end
    @(negedge clk);
    chk("b2b end x_valid", xv_m, 1'b0);
    chk("b2b end busy", busy_m, 1'b0);

    // Accept on the last bit with the buffer empty: FF then 81 direct
    s2 = 16'hFF81;
    data_m = 8'hFF; valid_m = 1'b1;
    @(posedge clk); #1;
    valid_m = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk($sformatf("lastacc c%0d x_valid", c), xv_m, 1'b1);
      chk($sformatf("lastacc c%0d x", c),       x_m, s2[16-c]);
      chk($sformatf("lastacc c%0d last", c),    last_m, (c == 8) || (c == 16));
      chk($sformatf("lastacc c%0d ready", c),   ready_m, 1'b1);
      @(posedge clk); #1;
      if (c == 7) begin data_m = 8'h81; valid_m = 1'b1; end
      if (c == 8) valid_m = 1'b0;
    end
    @(negedge clk);
    chk("lastacc end x_valid", xv_m, 1'b0);

    // Reset mid-word: A5 shifting, 3C pending, reset during bit 3
    data_m = 8'hA5; valid_m = 1'b1;
    @(posedge clk); #1;
    data_m = 8'h3C;
    @(posedge clk); #1;
    valid_m = 1'b0;
    @(posedge clk); #1;
    chk("midrst pre ready", ready_m, 1'b0);
    chk("midrst pre x_valid", xv_m, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("midrst x_valid", xv_m, 1'b0);
    chk("midrst ready", ready_m, 1'b1);
    chk("midrst busy", busy_m, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");
    run_word("post_rst_C3", 1'b0, 8'hC3, 8'b1100_0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
